// File: rtl/mc_mem_responder_if.sv
// Request/response bundle between the multicycle controller's memory strobes and mc_mem_responder.
// o_err and its modport entries exist only when MEM_ALIGN_CHECK_EN is defined.
interface mc_mem_responder_if;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        o_err;

    modport slave (
        input  i_mem_read, i_mem_write, i_addr, i_wdata,
        output o_rdata, o_ready, o_busy, o_err
    );

    modport master (
        output i_mem_read, i_mem_write, i_addr, i_wdata,
        input  o_rdata, o_ready, o_busy, o_err
    );
`else
    modport slave (
        input  i_mem_read, i_mem_write, i_addr, i_wdata,
        output o_rdata, o_ready, o_busy
    );

    modport master (
        output i_mem_read, i_mem_write, i_addr, i_wdata,
        input  o_rdata, o_ready, o_busy
    );
`endif
endinterface

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory for the multicycle MIPS datapath: LATENCY wait states, one-cycle ready pulse.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses on o_err (misaligned writes dropped, reads return 0).
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    mc_mem_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_cnt;
    logic [3:0]    w_next_cnt;
    logic          w_req;
    logic          w_accept;
    logic          w_commit;
    logic          w_mem_we;
    logic          w_misaligned;
    logic          r_op_write;
    logic [AW-1:0] r_word;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_busy;
    logic [31:0]   r_mem [DEPTH_WORDS];

    assign w_req    = bus.i_mem_read | bus.i_mem_write;
    assign w_mem_we = w_commit & r_op_write & ~w_misaligned;

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] r_lo;
    logic       r_err;
    logic       w_unused_addr_bits;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return (lo != 2'b00);
    endfunction

    assign w_misaligned       = is_misaligned(r_lo);
    assign w_unused_addr_bits = ^bus.i_addr[31:AW+2];
    assign bus.o_err          = r_err;

    // Byte offset of the latched access, needed only for the alignment check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo <= 2'b00;
        end else if (w_accept) begin
            r_lo <= bus.i_addr[1:0];
        end
    end
`else
    logic w_unused_addr_bits;

    assign w_misaligned       = 1'b0;
    assign w_unused_addr_bits = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0]};
`endif

    // State, wait counter and the request captured at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_op_write <= 1'b0;
            r_word     <= {AW{1'b0}};
            r_wdata    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_op_write <= bus.i_mem_write;
                r_word     <= bus.i_addr[AW+1:2];
                r_wdata    <= bus.i_wdata;
            end
        end
    end

    // Next state; requests are only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_BUSY;
                    w_next_cnt   = LAT_LOAD;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                    w_commit     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Registered handshake outputs; rdata only moves when a read commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_ready <= (w_next_state == ST_DONE);
            r_busy  <= (w_next_state == ST_BUSY);
            if (w_commit && !r_op_write) begin
                r_rdata <= w_misaligned ? 32'd0 : r_mem[r_word];
            end
`ifdef MEM_ALIGN_CHECK_EN
            r_err   <= w_commit & w_misaligned;
`endif
        end
    end

    // Storage array: no reset, contents undefined until written
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_word] <= r_wdata;
        end
    end

    assign bus.o_rdata = r_rdata;
    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder: timeline reference model plus directed and random accesses.
module tb_mc_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_mem_responder_if bus();

    mc_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: an access sampled at edge t0 commits at t0+LAT+1 and is retired at t0+LAT+2.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_active      = 1'b0;
    int          m_t0          = 0;
    int          k             = 0;
    bit          m_write       = 1'b0;
    bit          m_mis         = 1'b0;
    logic [31:0] m_addr        = 32'd0;
    logic [31:0] m_wdata       = 32'd0;
    logic [31:0] m_rdata       = 32'd0;
    bit          m_rdata_known = 1'b1;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active      = 1'b0;
                m_rdata       = 32'd0;
                m_rdata_known = 1'b1;
                k             = 0;
            end else begin
                k++;
                if (m_active && k == m_t0 + LAT + 1) begin
                    int w;
                    w = int'((m_addr >> 2) % DEPTH);
                    if (m_write) begin
                        if (!m_mis) begin
                            m_mem[w]   = m_wdata;
                            m_known[w] = 1'b1;
                        end
                    end else if (m_mis) begin
                        m_rdata       = 32'd0;
                        m_rdata_known = 1'b1;
                    end else begin
                        m_rdata       = m_mem[w];
                        m_rdata_known = m_known[w];
                    end
                end
                if (m_active && k == m_t0 + LAT + 2) begin
                    m_active = 1'b0;
                end else if (!m_active && (bus.i_mem_read || bus.i_mem_write)) begin
                    m_active = 1'b1;
                    m_t0     = k;
                    m_write  = bus.i_mem_write;
                    m_addr   = bus.i_addr;
                    m_wdata  = bus.i_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                    m_mis    = (bus.i_addr[1:0] != 2'b00);
`else
                    m_mis    = 1'b0;
`endif
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge
    initial begin
        forever begin
            bit exp_busy;
            bit exp_ready;
            @(negedge clk);
            if (!rst) begin
                exp_busy  = m_active && (k <= m_t0 + LAT);
                exp_ready = m_active && (k == m_t0 + LAT + 1);
                check("busy", 32'(bus.o_busy), 32'(exp_busy));
                check("ready", 32'(bus.o_ready), 32'(exp_ready));
                if (m_rdata_known) check("rdata", bus.o_rdata, m_rdata);
`ifdef MEM_ALIGN_CHECK_EN
                check("err", 32'(bus.o_err), 32'(exp_ready && m_mis));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request has been dropped.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_rdata, output logic got_err,
                          output int busy_cycles, output int wait_cycles);
        bus.i_mem_read  = rd;
        bus.i_mem_write = wr;
        bus.i_addr      = a;
        bus.i_wdata     = d;
        busy_cycles = 0;
        wait_cycles = 0;
        got_rdata   = 32'd0;
        got_err     = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.o_busy) busy_cycles++;
            if (bus.o_ready) begin
                wait_cycles = n;
                got_rdata   = bus.o_rdata;
`ifdef MEM_ALIGN_CHECK_EN
                got_err     = bus.o_err;
`endif
                break;
            end
        end
        if (wait_cycles == 0) begin
            n_total++;
            $display("FAIL ready_timeout: ready not seen in 40 cycles, required after %0d", LAT + 3);
        end
        @(posedge clk);
        #1;
        bus.i_mem_read  = 1'b0;
        bus.i_mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd_v;
        logic        err_v;
        int          bc;
        int          wc;

        bus.i_mem_read  = 1'b0;
        bus.i_mem_write = 1'b0;
        bus.i_addr      = 32'd0;
        bus.i_wdata     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.o_rdata, 32'd0);
        check("reset_ready", 32'(bus.o_ready), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("reset_err", 32'(bus.o_err), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, rd_v, err_v, bc, wc);
        check("wr_ready_latency", 32'(wc), 32'd5);
        check("wr_busy_cycles", 32'(bc), 32'd3);
        access(1'b1, 1'b0, 32'h40, 32'h0, rd_v, err_v, bc, wc);
        check("rd_0x40", rd_v, 32'hCAFEF00D);
        check("rd_busy_cycles", 32'(bc), 32'd3);

        access(1'b0, 1'b1, 32'h24, 32'h0BADF00D, rd_v, err_v, bc, wc);
        access(1'b1, 1'b0, 32'h24, 32'h0, rd_v, err_v, bc, wc);
        check("rd_0x24", rd_v, 32'h0BADF00D);
        access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, rd_v, err_v, bc, wc);
        check("both_keeps_rdata", rd_v, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h20, 32'h0, rd_v, err_v, bc, wc);
        check("rd_0x20_after_both", rd_v, 32'hA5A5A5A5);

        access(1'b0, 1'b1, 32'h400, 32'h55AA55AA, rd_v, err_v, bc, wc);
        access(1'b1, 1'b0, 32'h0, 32'h0, rd_v, err_v, bc, wc);
        check("wrap_rd_0x0", rd_v, 32'h55AA55AA);

`ifdef MEM_ALIGN_CHECK_EN
        access(1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, rd_v, err_v, bc, wc);
        check("mis_wr_err", 32'(err_v), 32'd1);
        access(1'b1, 1'b0, 32'h0, 32'h0, rd_v, err_v, bc, wc);
        check("mis_wr_suppressed", rd_v, 32'h55AA55AA);
        check("aligned_rd_err", 32'(err_v), 32'd0);
        access(1'b1, 1'b0, 32'h3, 32'h0, rd_v, err_v, bc, wc);
        check("mis_rd_rdata", rd_v, 32'd0);
        check("mis_rd_err", 32'(err_v), 32'd1);
`endif

        access(1'b0, 1'b1, 32'h10, 32'h11111111, rd_v, err_v, bc, wc);
        bus.i_mem_write = 1'b1;
        bus.i_addr      = 32'h10;
        bus.i_wdata     = 32'hDEADBEEF;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.o_busy), 32'd0);
        check("rst_mid_ready", 32'(bus.o_ready), 32'd0);
        check("rst_mid_rdata", bus.o_rdata, 32'd0);
        bus.i_mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b1, 1'b0, 32'h10, 32'h0, rd_v, err_v, bc, wc);
        check("rd_after_abort", rd_v, 32'h11111111);

        for (int t = 0; t < 200; t++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a    = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            access(kind != 1, kind == 1 || kind == 2, a, $urandom, rd_v, err_v, bc, wc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
